// File: rtl/code_conv_sched.sv
// Round-robin arbiter that time-shares one bank of combinational code converters
// (BCD, Gray, Hamming) among three requesters and returns the registered result.
module code_conv_sched #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [11:0] req_data,
    input  logic [5:0]  req_code,
    output logic [3:0]  bn,
    input  logic [3:0]  bcd_in,
    input  logic [3:0]  gray_in,
    input  logic [6:0]  ham_in,
    output logic [2:0]  grant,
    output logic        busy,
    output logic        done,
    output logic [6:0]  result,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  bn_q, bn_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  code_q, code_d;
    logic [2:0]  grant_q, grant_d;
    logic [6:0]  result_q, result_d;
    logic        err_q, err_d;
    logic [1:0]  cand0, cand1, pick;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Search order starts just after the previous owner; the previous owner is last.
    always_comb begin
        cand0 = nxt(last_q);
        cand1 = nxt(cand0);
        if (req[cand0])      pick = cand0;
        else if (req[cand1]) pick = cand1;
        else                 pick = last_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bn_d     = bn_q;
        last_d   = last_q;
        code_d   = code_q;
        grant_d  = grant_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    bn_d    = req_data[{pick, 2'b00} +: 4];
                    code_d  = req_code[{pick, 1'b0} +: 2];
                    grant_d = 3'b001 << pick;
                    last_d  = pick;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                // Converter outputs are sampled on the edge the counter hits zero.
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    case (code_q)
                        2'b00:   result_d = {3'b000, bcd_in};
                        2'b01:   result_d = {3'b000, gray_in};
                        2'b10:   result_d = ham_in;
                        default: begin
                            result_d = '0;
                            err_d    = 1'b1;
                        end
                    endcase
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bn_q     <= '0;
            last_q   <= 2'd2;
            code_q   <= '0;
            grant_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bn_q     <= bn_d;
            last_q   <= last_d;
            code_q   <= code_d;
            grant_q  <= grant_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign bn     = bn_q;
    assign grant  = grant_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign err    = err_q;

endmodule

// File: doc/code_conv_sched.md
# code_conv_sched

Round-robin scheduler that shares one set of combinational code converters (binary→BCD, binary→Gray, binary→even-parity Hamming) among three requesters. Each requester presents a 4-bit binary value and a code select. The block grants one requester at a time and drives the shared converter input `bn`. After a settle interval it registers the selected converter output and returns it with a one-cycle `done` pulse. It sits between the converter bank and the client logic (display drivers, serial encoders) in the lab top level.

## Interface
- `WAIT_CYCLES`, default 1: number of cycles `bn` is held before sampling the converter outputs; legal range 1..15.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- `req`  in  3  request per requester; bit i = requester i.
- `req_data`  in  12  binary value per requester; requester i owns bits [4i+3:4i].
- `req_code`  in  6  code select per requester, bits [2i+1:2i]: 00 = BCD, 01 = Gray, 10 = Hamming, 11 = invalid.
- `bn`  out  4  value driven to the shared converters.
- `bcd_in`  in  4  BCD converter output.
- `gray_in`  in  4  Gray converter output.
- `ham_in`  in  7  Hamming converter output.
- `grant`  out  3  one-hot owner of the current transaction; 0 when idle.
- `busy`  out  1  high whenever a transaction is in progress.
- `done`  out  1  one-cycle pulse; `result` and `err` are valid in that cycle.
- `result`  out  7  converted value. BCD and Gray are zero-extended to {3'b000, x}; Hamming is passed through.
- `err`  out  1  high with `done` when the latched code select was 11. In that case `result` = 0.

## Operation
- Reset values: state IDLE; `grant` = 0; `busy` = 0; `done` = 0; `result` = 0; `err` = 0; `bn` = 0; wait counter = 0; round-robin pointer `last` = 2, so requester 0 has top priority after reset.
- FSM states: IDLE → SETTLE → DONE → IDLE.
- IDLE: if any `req` bit is 1, select the first set bit searching `last+1`, `last+2`, `last+3` (mod 3).
  - On that edge: latch the owner's data into `bn` and its code into an internal register.
  - Set `grant` to the owner's one-hot value, set `busy` = 1, set `last` = owner, load the counter with `WAIT_CYCLES`, and go to SETTLE.
  - If no request is present, remain in IDLE.
- SETTLE: decrement the counter each cycle. On the edge where the counter reaches 0:
  - Register `result` from `bcd_in`, `gray_in` or `ham_in` per the latched code, or 0 with `err` = 1 for code 11.
  - Set `done` = 1 and go to DONE.
- DONE: `done`, `grant` and `busy` stay high for exactly this one cycle. On the next edge go to IDLE and clear `done`, `grant`, `busy` and `err`.
  - `result` holds its last value until the next DONE.
  - `bn` holds its last value until the next grant.
- Handshake: a requester holds `req` until it sees `done` with its `grant` bit set, then drops `req`. If `req` is still high in IDLE, it is a new request and competes normally.
- `req`, `req_data` and `req_code` may change during SETTLE or DONE without effect; the latched values are used.
- A withdrawn `req` during a transaction does not abort it; `done` still pulses for the owner.
- A request arriving while another transaction is in progress waits; there is no preemption.
- Fairness: with all three requests held continuously, grants rotate 0, 1, 2, 0, …

## Timing
- The request is sampled at IDLE edge E.
  - `grant`, `busy` and `bn` are valid from edge E.
  - `done` and `result` are valid from edge E+WAIT_CYCLES.
  - The block returns to IDLE at edge E+WAIT_CYCLES+1.
- The earliest next grant is at edge E+WAIT_CYCLES+2. With `WAIT_CYCLES` = 1, one transaction completes every 3 cycles.
- `reset` = 0 at any point, including mid-SETTLE or during DONE:
  - All outputs go to their reset values without waiting for a clock edge.
  - The in-flight transaction is discarded with no `done` pulse.
  - After reset is released, arbitration restarts with requester 0 first.
- `bn` is constant from grant until the following grant, so the converter outputs are stable while sampled.

## Test plan
- Reset: hold `reset` = 0 with random inputs → `grant` = 000, `done` = 0, `result` = 0, `bn` = 0.
- Single request, `WAIT_CYCLES` = 1: `req` = 001, data0 = 4'd9, code0 = 00, `bcd_in` = 4'b1001 → `grant` = 001 and `bn` = 9 after 1 edge; `done` with `result` = 7'b0001001 after 2 edges.
- Round robin: `req` = 111 held, codes = 01, data = 3/5/12 → grant order 001, 010, 100, 001. Gray results are 0000010, 0000111 and 0001010 respectively, with one transaction every 3 cycles.
- Hamming and invalid code: data = 4'd11 with code 10 → `result` = `ham_in` pass-through (drive 7'b1010101 → read 7'b1010101); code 11 → `err` = 1, `result` = 0.
- Robustness: change `req_data` during SETTLE → `bn` is unchanged. Drop `req` in SETTLE → `done` still pulses. Assert `reset` = 0 mid-SETTLE → no `done`, and requester 0 wins next.
- Settle parameter: `WAIT_CYCLES` = 4 → `done` exactly 4 edges after grant. `bn` is stable throughout, and `result` reflects `bcd_in` at the sampling edge, not earlier values.
